// File: rtl/shift_unit.sv
// Shift execution-unit wrapper: S1 operand register, shifter, result buffer toward writeback.
// Define SHIFT_UNIT_SKID_EN for a 2-entry result FIFO with same-cycle push/pop (1 op/cycle).
module shift_unit #(
    parameter int XLEN = 32,
    parameter int ID_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            issue_valid,
    output logic            issue_ready,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [4:0]      imm,
    input  logic            use_imm,
    input  logic [2:0]      fn3,
    input  logic            fn7_b5,
    input  logic [ID_W-1:0] instr_id,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_rd,
    output logic [ID_W-1:0] wb_id
);

    logic            s1_valid;
    logic [XLEN-1:0] s1_rs1;
    logic [4:0]      s1_amt;
    logic            s1_left;
    logic            s1_arith;
    logic [ID_W-1:0] s1_id;

    logic            buf_accept;
    logic            s1_adv;
    logic            issue_fire;
    logic            pop;

    logic [XLEN-1:0]   sh_data;
    logic              sh_fill;
    logic [2*XLEN-1:0] sh_ext;
    logic [XLEN-1:0]   sh_out;
    logic [XLEN-1:0]   sh_res;

    logic unused_rs2;
    assign unused_rs2 = ^rs2[XLEN-1:5];

    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) begin
            r[i] = d[XLEN-1-i];
        end
        return r;
    endfunction

    // Flush wins over a push into the result buffer.
    assign s1_adv      = s1_valid && buf_accept && !flush;
    assign issue_ready = !rst && !flush && (!s1_valid || s1_adv);
    assign issue_fire  = issue_valid && issue_ready;
    assign pop         = wb_valid && wb_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid <= 1'b0;
        end else if (issue_fire) begin
            s1_valid <= 1'b1;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (issue_fire) begin
            s1_rs1   <= rs1;
            s1_amt   <= use_imm ? imm : rs2[4:0];
            s1_left  <= (fn3 == 3'b001);
            s1_arith <= (fn3 == 3'b101) && fn7_b5;
            s1_id    <= instr_id;
        end
    end

    // The shifter only shifts right; left shifts go through a bit-reversal on both sides.
    always_comb begin
        sh_data = s1_left ? bit_rev(s1_rs1) : s1_rs1;
        sh_fill = !s1_left && s1_arith && s1_rs1[XLEN-1];
        sh_ext  = {{XLEN{sh_fill}}, sh_data} >> s1_amt;
        sh_out  = sh_ext[XLEN-1:0];
        sh_res  = s1_left ? bit_rev(sh_out) : sh_out;
    end

`ifdef SHIFT_UNIT_SKID_EN
    logic            tail_valid;
    logic [XLEN-1:0] tail_rd;
    logic [ID_W-1:0] tail_id;

    // Head entry is the output register so the last popped value stays visible.
    assign buf_accept = !tail_valid || pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_id      <= '0;
            tail_valid <= 1'b0;
            tail_rd    <= '0;
            tail_id    <= '0;
        end else if (flush) begin
            wb_valid   <= 1'b0;
            tail_valid <= 1'b0;
        end else if (pop) begin
            if (tail_valid) begin
                wb_rd <= tail_rd;
                wb_id <= tail_id;
                if (s1_adv) begin
                    tail_rd <= sh_res;
                    tail_id <= s1_id;
                end else begin
                    tail_valid <= 1'b0;
                end
            end else if (s1_adv) begin
                wb_rd <= sh_res;
                wb_id <= s1_id;
            end else begin
                wb_valid <= 1'b0;
            end
        end else if (s1_adv) begin
            if (!wb_valid) begin
                wb_valid <= 1'b1;
                wb_rd    <= sh_res;
                wb_id    <= s1_id;
            end else begin
                tail_valid <= 1'b1;
                tail_rd    <= sh_res;
                tail_id    <= s1_id;
            end
        end
    end
`else
    assign buf_accept = !wb_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_id    <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (s1_adv) begin
            wb_valid <= 1'b1;
            wb_rd    <= sh_res;
            wb_id    <= s1_id;
        end else if (pop) begin
            wb_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed cases plus random traffic against a queue model.
module tb_shift_unit;
    localparam int XLEN = 32;
    localparam int ID_W = 3;
`ifdef SHIFT_UNIT_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            issue_valid;
    logic            issue_ready;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [4:0]      imm;
    logic            use_imm;
    logic [2:0]      fn3;
    logic            fn7_b5;
    logic [ID_W-1:0] instr_id;
    logic            wb_valid;
    logic            wb_ready;
    logic [XLEN-1:0] wb_rd;
    logic [ID_W-1:0] wb_id;

    shift_unit #(.XLEN(XLEN), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .imm(imm), .use_imm(use_imm),
        .fn3(fn3), .fn7_b5(fn7_b5), .instr_id(instr_id),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_id(wb_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [XLEN-1:0] rd;
        logic [ID_W-1:0] id;
    } exp_t;

    exp_t            exp_q[$];
    logic [ID_W-1:0] popped[$];
    int              n_checks = 0;
    int              n_fail = 0;
    int              cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [XLEN-1:0] ref_shift(input logic [XLEN-1:0] a, input logic [4:0] amt,
                                                  input logic [2:0] f3, input logic f7);
        if (f3 == 3'b001) return a << amt;
        else if (f7) return $signed(a) >>> amt;
        else return a >> amt;
    endfunction

    // Model: every accepted op is queued; pops compare in order; flush or reset drops everything.
    logic            prev_stall;
    logic [XLEN-1:0] prev_rd;
    logic [ID_W-1:0] prev_id;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", wb_valid, 1);
                check("hold_rd", wb_rd, prev_rd);
                check("hold_id", wb_id, prev_id);
            end
            if (wb_valid && wb_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wb_rd", wb_rd, e.rd);
                    check("wb_id", wb_id, e.id);
                end
                popped.push_back(wb_id);
            end
            if (flush) exp_q.delete();
            if (issue_valid && issue_ready) begin
                exp_q.push_back('{rd: ref_shift(rs1, use_imm ? imm : rs2[4:0], fn3, fn7_b5),
                                  id: instr_id});
            end
            prev_stall <= wb_valid && !wb_ready && !flush;
            prev_rd    <= wb_rd;
            prev_id    <= wb_id;
        end
    end

    task automatic wait_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic load_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] im,
                           input logic ui, input logic [2:0] f3, input logic f7,
                           input logic [ID_W-1:0] id);
        rs1 = a; rs2 = b; imm = im; use_imm = ui; fn3 = f3; fn7_b5 = f7; instr_id = id;
    endtask

    task automatic load_rand(input logic [ID_W-1:0] id);
        load_op($urandom, $urandom, 5'($urandom), 1'($urandom),
                ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101, 1'($urandom), id);
    endtask

    // Issue one op on an idle unit and check latency and result directly.
    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] im, input logic ui, input logic [2:0] f3,
                            input logic f7, input logic [ID_W-1:0] id, input logic [31:0] exp);
        bit ok;
        ok = 1'b0;
        repeat (3) to_drive();
        load_op(a, b, im, ui, f3, f7, id);
        issue_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wait_neg();
            if (issue_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, "_accept"}, ok, 1);
        to_drive();
        issue_valid = 1'b0;
        wait_neg();
        check({tag, "_lat_early"}, wb_valid, 0);
        wait_neg();
        check({tag, "_lat_valid"}, wb_valid, 1);
        check({tag, "_rd"}, wb_rd, exp);
        check({tag, "_id"}, wb_id, id);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int sent;
        int t_first;
        int t_last;
        bit fired;
        logic [XLEN-1:0] snap_rd;
        logic [ID_W-1:0] snap_id;

        rst = 1'b1; flush = 1'b0; wb_ready = 1'b0; issue_valid = 1'b1;
        load_op(32'h1234_5678, 32'h3, 5'd1, 1'b0, 3'b001, 1'b0, 3'd7);

        // Reset hold
        repeat (3) begin
            wait_neg();
            check("rst_issue_ready", issue_ready, 0);
        end
        to_drive();
        rst = 1'b0;
        issue_valid = 1'b0;
        repeat (2) begin
            wait_neg();
            check("rst_wb_valid", wb_valid, 0);
            check("rst_wb_rd", wb_rd, 0);
            check("rst_wb_id", wb_id, 0);
        end

        // Basic ops and source select
        wb_ready = 1'b1;
        directed("sll", 32'h8000_00F0, 32'h0, 5'd4, 1'b1, 3'b001, 1'b0, 3'd1, 32'h0000_0F00);
        directed("srl", 32'h8000_00F0, 32'h0, 5'd4, 1'b1, 3'b101, 1'b0, 3'd2, 32'h0800_000F);
        directed("sra", 32'h8000_00F0, 32'h0, 5'd4, 1'b1, 3'b101, 1'b1, 3'd3, 32'hF800_000F);
        directed("imm_sel", 32'h1, 32'h1, 5'd31, 1'b1, 3'b001, 1'b0, 3'd4, 32'h8000_0000);
        directed("rs2_sel", 32'h1, 32'h1, 5'd31, 1'b0, 3'b001, 1'b0, 3'd5, 32'h0000_0002);
        directed("sra_amt0", 32'h8000_0001, 32'h20, 5'd0, 1'b0, 3'b101, 1'b1, 3'd6, 32'h8000_0001);
        directed("srl_rs2", 32'hF000_0000, 32'hFFFF_FFE4, 5'd0, 1'b0, 3'b101, 1'b0, 3'd0, 32'h0F00_0000);

        // Backpressure
        repeat (3) to_drive();
        wb_ready = 1'b0;
        popped.delete();
        accepted = 0;
        load_rand(3'd1);
        issue_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            wait_neg();
            fired = issue_valid && issue_ready;
            if (fired) accepted++;
            to_drive();
            if (accepted >= 3) issue_valid = 1'b0;
            else if (fired) load_rand(3'(accepted + 1));
        end
        check("bp_accepted", accepted, SKID ? 3 : 2);
        check("bp_ready_low", issue_ready, 0);
        check("bp_head_id", wb_id, 1);
        snap_rd = wb_rd;
        snap_id = wb_id;
        repeat (3) wait_neg();
        check("bp_stable_rd", wb_rd, snap_rd);
        check("bp_stable_id", wb_id, snap_id);
        to_drive();
        wb_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            wait_neg();
            fired = issue_valid && issue_ready;
            if (fired) accepted++;
            if (accepted >= 3 && popped.size() >= 3) break;
            to_drive();
            if (accepted >= 3) issue_valid = 1'b0;
            else if (fired) load_rand(3'(accepted + 1));
        end
        check("bp_count", popped.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < popped.size()) check("bp_order", popped[i], i + 1);
        end

        // Throughput
        to_drive();
        issue_valid = 1'b0;
        repeat (4) to_drive();
        popped.delete();
        sent = 0;
        t_first = 0;
        t_last = 0;
        load_rand(3'd0);
        issue_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            wait_neg();
            if (issue_valid && issue_ready) begin
                if (sent == 0) t_first = cyc;
                sent++;
                fired = 1'b1;
            end else begin
                fired = 1'b0;
            end
            if (popped.size() >= 8) begin
                t_last = cyc;
                break;
            end
            to_drive();
            if (sent >= 8) issue_valid = 1'b0;
            else if (fired) load_rand(3'(sent));
        end
        check("tput_count", popped.size(), 8);
        check("tput_cycles", t_last - t_first, SKID ? 9 : 16);

        // Flush
        to_drive();
        issue_valid = 1'b0;
        repeat (4) to_drive();
        popped.delete();
        load_rand(3'd5);
        issue_valid = 1'b1;
        wait_neg();
        check("fl_accept5", issue_ready, 1);
        to_drive();
        flush = 1'b1;
        load_rand(3'd6);
        wait_neg();
        check("fl_ready_low", issue_ready, 0);
        to_drive();
        flush = 1'b0;
        issue_valid = 1'b0;
        wait_neg();
        check("fl_wb_valid", wb_valid, 0);
        repeat (4) wait_neg();
        check("fl_no_results", popped.size(), 0);
        directed("post_flush", 32'h0000_00FF, 32'h0, 5'd8, 1'b1, 3'b001, 1'b0, 3'd7, 32'h0000_FF00);

        // Random traffic with occasional flush and reset
        for (int c = 0; c < 400; c++) begin
            to_drive();
            rst = ($urandom_range(0, 99) < 1);
            flush = ($urandom_range(0, 99) < 3);
            wb_ready = ($urandom_range(0, 99) < 70);
            issue_valid = ($urandom_range(0, 99) < 60);
            load_rand(3'($urandom));
        end

        to_drive();
        rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; wb_ready = 1'b1;
        repeat (10) wait_neg();
        check("drain_empty", exp_q.size(), 0);
        check("drain_wb_valid", wb_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
